// File: rtl/systolic_seq_ctrl.sv
// Operand sequencer for an (N+1)-cell MAC chain: clear, feed k_len pairs with bubbles on stall, drain, pulse done.
// Optional SEQ_CTRL_PERF_EN adds stall_cnt and job_cycles performance counters.
module systolic_seq_ctrl #(
   parameter int N          = 2,
   parameter int DATA_WIDTH = 32,
   parameter int KW         = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [KW-1:0]         k_len,
   input  logic                  src_valid,
   output logic                  src_ready,
   input  logic [DATA_WIDTH-1:0] src_a,
   input  logic [DATA_WIDTH-1:0] src_b,
   output logic                  mac_clr,
   output logic [DATA_WIDTH-1:0] a_out,
   output logic [DATA_WIDTH-1:0] b_out,
   output logic                  busy,
   output logic                  done
`ifdef SEQ_CTRL_PERF_EN
   ,
   output logic [31:0]           stall_cnt,
   output logic [31:0]           job_cycles
`endif
);

   // state  | meaning
   // IDLE   | waiting for start
   // CLEAR  | one cycle of mac_clr
   // FEED   | accepting operand pairs, bubbles on stall
   // DRAIN  | N+2 cycles of zeros while the chain settles
   // DONE   | one-cycle done pulse
   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_DONE} state_t;

   localparam int DRW = $clog2(N + 2) + 1;

   state_t                state_q, state_d;
   logic [KW-1:0]         beat_q, beat_d;
   logic [DRW-1:0]        drain_q, drain_d;
   logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic                  accept;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         beat_q  <= '0;
         drain_q <= '0;
         a_q     <= '0;
         b_q     <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         drain_q <= drain_d;
         a_q     <= a_d;
         b_q     <= b_d;
      end
   end

   assign accept = src_ready & src_valid;

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      drain_d = drain_q;
      a_d     = '0;
      b_d     = '0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               beat_d  = k_len;
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            if (beat_q != '0) begin
               state_d = S_FEED;
            end else begin
               state_d = S_DRAIN;
               drain_d = DRW'(N + 1);
            end
         end
         S_FEED: begin
            if (accept) begin
               a_d    = src_a;
               b_d    = src_b;
               beat_d = beat_q - KW'(1);
               // the cycle of the last accept already moves on to DRAIN
               if (beat_q == KW'(1)) begin
                  state_d = S_DRAIN;
                  drain_d = DRW'(N + 1);
               end
            end
         end
         S_DRAIN: begin
            if (drain_q == '0) state_d = S_DONE;
            else               drain_d = drain_q - DRW'(1);
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      src_ready = (state_q == S_FEED) && (beat_q != '0);
      mac_clr   = (state_q == S_CLEAR);
      busy      = (state_q != S_IDLE);
      done      = (state_q == S_DONE);
      a_out     = a_q;
      b_out     = b_q;
   end

`ifdef SEQ_CTRL_PERF_EN
   logic [31:0] stall_q, stall_d, jobc_q, jobc_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
         jobc_q  <= '0;
      end else begin
         stall_q <= stall_d;
         jobc_q  <= jobc_d;
      end
   end

   always_comb begin
      stall_d = stall_q;
      jobc_d  = jobc_q;
      if (state_q == S_IDLE && start) begin
         stall_d = '0;
         jobc_d  = '0;
      end else begin
         if (src_ready && !src_valid) stall_d = stall_q + 32'd1;
         if (busy)                    jobc_d  = jobc_q + 32'd1;
      end
   end

   assign stall_cnt  = stall_q;
   assign job_cycles = jobc_q;
`endif

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Randomized self-checking bench for systolic_seq_ctrl; a job is modelled as a valid pattern
// over FEED cycles from which all expected per-cycle outputs are derived.
module tb_systolic_seq_ctrl;
   localparam int N  = 2;
   localparam int DW = 32;
   localparam int KW = 8;

   logic          clk = 1'b0;
   logic          rst, start, src_valid;
   logic [KW-1:0] k_len;
   logic [DW-1:0] src_a, src_b, a_out, b_out;
   logic          src_ready, mac_clr, busy, done;
`ifdef SEQ_CTRL_PERF_EN
   logic [31:0]   stall_cnt, job_cycles;
`endif

   int n_cmp = 0;
   int n_err = 0;

   // job model: vq[i] is src_valid on the i-th FEED cycle, aq/bq the data offered then
   bit            vq[$];
   logic [DW-1:0] aq[$];
   logic [DW-1:0] bq[$];

   systolic_seq_ctrl #(.N(N), .DATA_WIDTH(DW), .KW(KW)) dut (
      .clk(clk), .rst(rst), .start(start), .k_len(k_len),
      .src_valid(src_valid), .src_ready(src_ready), .src_a(src_a), .src_b(src_b),
      .mac_clr(mac_clr), .a_out(a_out), .b_out(b_out), .busy(busy), .done(done)
`ifdef SEQ_CTRL_PERF_EN
      , .stall_cnt(stall_cnt), .job_cycles(job_cycles)
`endif
   );

   always #5 clk = ~clk;

   task automatic gen_job(input int k, input int stall_pct);
      int ones;
      bit v;
      vq.delete(); aq.delete(); bq.delete();
      ones = 0;
      while (ones < k) begin
         v = ($urandom_range(99) >= stall_pct);
         vq.push_back(v);
         aq.push_back($urandom);
         bq.push_back($urandom);
         if (v) ones++;
      end
   endtask

   // Runs one job from IDLE; cycle 0 carries start, expectations follow from the valid pattern.
   task automatic run_job(input int k, input bit hold_start);
      int f, d;
      bit e_busy, e_done, e_clr, e_rdy;
      logic [DW-1:0] e_a, e_b;
      f = vq.size();
      d = f + N + 4;
      for (int c = 0; c <= d + 1; c++) begin
         if (c == 0)        start = 1'b1;
         else if (c > d)   start = 1'b0;
         else if (hold_start) start = 1'b1;
         else               start = ($urandom_range(3) == 0);
         k_len = (c == 0) ? KW'(k) : KW'($urandom);
         if (c >= 2 && c - 2 < f) begin
            src_valid = vq[c-2]; src_a = aq[c-2]; src_b = bq[c-2];
         end else begin
            src_valid = $urandom_range(1); src_a = $urandom; src_b = $urandom;
         end
         @(negedge clk);
         e_busy = (c >= 1 && c <= d);
         e_done = (c == d);
         e_clr  = (c == 1);
         e_rdy  = (c >= 2 && c < 2 + f);
         e_a = '0; e_b = '0;
         if (c >= 3 && c - 3 < f && vq[c-3]) begin
            e_a = aq[c-3]; e_b = bq[c-3];
         end
         n_cmp += 5;
         if (busy !== e_busy) begin n_err++; $display("FAIL busy k=%0d c=%0d got=%b exp=%b", k, c, busy, e_busy); end
         if (done !== e_done) begin n_err++; $display("FAIL done k=%0d c=%0d got=%b exp=%b", k, c, done, e_done); end
         if (mac_clr !== e_clr) begin n_err++; $display("FAIL mac_clr k=%0d c=%0d got=%b exp=%b", k, c, mac_clr, e_clr); end
         if (src_ready !== e_rdy) begin n_err++; $display("FAIL src_ready k=%0d c=%0d got=%b exp=%b", k, c, src_ready, e_rdy); end
         if (a_out !== e_a || b_out !== e_b) begin
            n_err++;
            $display("FAIL operands k=%0d c=%0d got=%h/%h exp=%h/%h", k, c, a_out, b_out, e_a, e_b);
         end
         @(posedge clk); #1;
      end
`ifdef SEQ_CTRL_PERF_EN
      n_cmp += 2;
      if (stall_cnt !== 32'(f - k)) begin n_err++; $display("FAIL stall_cnt k=%0d got=%0d exp=%0d", k, stall_cnt, f - k); end
      if (job_cycles !== 32'(d)) begin n_err++; $display("FAIL job_cycles k=%0d got=%0d exp=%0d", k, job_cycles, d); end
`endif
   endtask

   task automatic check_idle(input string tag);
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0 || mac_clr !== 1'b0 || src_ready !== 1'b0 ||
          a_out !== '0 || b_out !== '0) begin
         n_err++;
         $display("FAIL %s got busy=%b done=%b clr=%b rdy=%b a=%h b=%h exp all 0",
                  tag, busy, done, mac_clr, src_ready, a_out, b_out);
      end
`ifdef SEQ_CTRL_PERF_EN
      n_cmp++;
      if (stall_cnt !== 32'd0 || job_cycles !== 32'd0) begin
         n_err++; $display("FAIL %s_perf got=%0d/%0d exp=0/0", tag, stall_cnt, job_cycles);
      end
`endif
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; k_len = '0; src_valid = 1'b0; src_a = '0; src_b = '0;
      repeat (2) @(posedge clk);
      #1; rst = 1'b0;
      @(negedge clk); check_idle("reset_state");
      @(posedge clk); #1;
      // start a long job, stall mid-FEED with a 2-cycle reset that also carries start
      start = 1'b1; k_len = 8'd10; src_valid = 1'b1; src_a = 32'hA5; src_b = 32'h5A;
      @(posedge clk); #1; start = 1'b0;
      repeat (3) @(posedge clk);
      #1; rst = 1'b1; start = 1'b1;
      @(posedge clk); @(negedge clk); check_idle("reset_mid_feed");
      @(posedge clk); #1; rst = 1'b0; start = 1'b0; src_valid = 1'b0;
      @(negedge clk); check_idle("reset_start_collide");
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      vq = '{1, 1, 1};
      aq = '{32'd1, 32'd2, 32'd3};
      bq = '{32'd4, 32'd5, 32'd6};
      run_job(3, 1'b0);
   endtask

   task automatic test_stall();
      vq = '{1, 1, 0, 0, 1, 1};
      aq = '{32'h11, 32'h22, 32'hDEAD, 32'hBEEF, 32'h33, 32'h44};
      bq = '{32'h55, 32'h66, 32'hCAFE, 32'hF00D, 32'h77, 32'h88};
      run_job(4, 1'b0);
   endtask

   task automatic test_zero_len();
      gen_job(0, 0);
      run_job(0, 1'b0);
   endtask

   task automatic test_start_held();
      gen_job(5, 30);
      run_job(5, 1'b1);
      gen_job(2, 0);
      run_job(2, 1'b0);
   endtask

   task automatic test_max_len();
      gen_job(255, 0);
      run_job(255, 1'b0);
   endtask

   task automatic test_back_to_back();
      int k;
      for (int j = 0; j < 12; j++) begin
         k = $urandom_range(20);
         gen_job(k, $urandom_range(60));
         run_job(k, j[0]);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_zero_len();
      test_start_held();
      test_max_len();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end
endmodule
